fpio_word_xmit: RTL and testbench

FPIO_WORD_XMIT -- requirements
Module: fpio_word_xmit

---
 rtl/fpio_pkg.sv | 13 +
 rtl/fpio_word_fifo2.sv | 57 +++++
 rtl/fpio_word_xmit.sv | 119 +++++++++++
 tb/tb_fpio_word_xmit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpio_pkg.sv
// Shared definitions for the FPIO word transmitter.
//   ser_state_t  : serializer state (IDLE, SEND)
//   WORDS_SENT_W : width of the transmitted-word counter
package fpio_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   localparam int WORDS_SENT_W = 16;

endpackage

// File: rtl/fpio_word_fifo2.sv
// Two-entry word FIFO used to buffer words ahead of the serializer.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   push, push_data: write request and data (ignored when full)
//   pop            : read request (ignored when empty)
//   head           : oldest stored word, valid when !empty
//   full, empty    : occupancy flags
module fpio_word_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: storage is deliberately left out of reset; only the pointers and
   // the count define what is valid, so clearing the data would buy nothing.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         // Simultaneous push and pop leave the occupancy unchanged.
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fpio_word_xmit.sv
// Word-to-beat serializer driving the transmit side of an FPIO link.
// Words are buffered in a 2-entry FIFO and sent LSB beat first.
// Ports:
//   clock, reset_n       : clock, synchronous active-low reset
//   in_dat/in_valid      : word input, accepted when in_valid && in_ready
//   in_ready             : FIFO has room (low while in reset)
//   DAT/DAT_v/DAT_r      : FPIO beat data, valid, and receiver ready
//   busy                 : a word is buffered or being transmitted
//   words_sent           : wrapping count of fully transmitted words
module fpio_word_xmit
   import fpio_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int WORD_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [WORD_WIDTH-1:0]   in_dat,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   DAT,
   output logic                    DAT_v,
   input  logic                    DAT_r,
   output logic                    busy,
   output logic [WORDS_SENT_W-1:0] words_sent
);

   localparam int BEATS = WORD_WIDTH / DATA_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   ser_state_t              state;
   logic [WORD_WIDTH-1:0]   shift_reg;
   logic [CNT_W-1:0]        beat_cnt;
   logic [WORDS_SENT_W-1:0] words_sent_q;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [WORD_WIDTH-1:0]   fifo_head;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    push;
   logic                    beat_done;
   logic                    load_idle;
   logic [WORD_WIDTH-1:0]   next_word;

   assign in_ready  = reset_n && !fifo_full;
   assign push      = in_valid && in_ready;
   assign beat_done = (state == SEND) && DAT_r;

   // An idle serializer with an empty FIFO takes the incoming word directly,
   // so the first beat appears the cycle after acceptance.
   assign load_idle = (state == IDLE) && (!fifo_empty || push);
   assign next_word = fifo_empty ? in_dat : fifo_head;
   assign fifo_push = push && !((state == IDLE) && fifo_empty);
   assign fifo_pop  = !fifo_empty &&
                      ((state == IDLE) || (beat_done && (beat_cnt == LAST_BEAT)));

   // The shift register drains to zero after the last beat, so DAT reads 0
   // whenever the serializer is idle.
   assign DAT        = shift_reg[DATA_WIDTH-1:0];
   assign DAT_v      = (state == SEND);
   assign busy       = (state == SEND) || !fifo_empty;
   assign words_sent = words_sent_q;

   fpio_word_fifo2 #(
      .WIDTH (WORD_WIDTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (in_dat),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= IDLE;
         shift_reg    <= '0;
         beat_cnt     <= '0;
         words_sent_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_idle) begin
                  shift_reg <= next_word;
                  beat_cnt  <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (beat_done) begin
                  if (beat_cnt == LAST_BEAT) begin
                     words_sent_q <= words_sent_q + 1'b1;
                     beat_cnt     <= '0;
                     // Back-to-back words: reload on the same edge, no bubble.
                     if (!fifo_empty) begin
                        shift_reg <= fifo_head;
                     end else begin
                        shift_reg <= '0;
                        state     <= IDLE;
                     end
                  end else begin
                     shift_reg <= shift_reg >> DATA_WIDTH;
                     beat_cnt  <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpio_word_xmit.sv
module tb_fpio_word_xmit;

   localparam int DW    = 4;
   localparam int WW    = 32;
   localparam int BEATS = WW / DW;

   logic          clock;
   logic          reset_n;
   logic [WW-1:0] in_dat;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] DAT;
   logic          DAT_v;
   logic          DAT_r;
   logic          busy;
   logic [15:0]   words_sent;

   int checks = 0;
   int errors = 0;

   // Reference model: words still owed to the link, beats already sent of
   // the head word, and the expected word counter.
   logic [WW-1:0] exp_words[$];
   int            idx = 0;
   logic [15:0]   exp_ws = 16'd0;
   bit            model_on = 1'b0;
   bit            stall_prev = 1'b0;
   logic [DW-1:0] stall_dat = '0;

   fpio_word_xmit #(
      .DATA_WIDTH (DW),
      .WORD_WIDTH (WW)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_dat     (in_dat),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .DAT        (DAT),
      .DAT_v      (DAT_v),
      .DAT_r      (DAT_r),
      .busy       (busy),
      .words_sent (words_sent)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check the current outputs against the model, record
   // handshakes that will happen on the coming edge, then advance to the
   // next falling edge where the bench drives new inputs.
   task automatic tick();
      logic          acc;
      logic          beat;
      logic          rn;
      logic [WW-1:0] w;
      #1;
      rn = reset_n;
      if (rn && model_on) begin
         chk("busy", 32'(busy), 32'(exp_words.size() != 0));
         chk("words_sent", 32'(words_sent), 32'(exp_ws));
         if (!DAT_v) chk("idle_dat", 32'(DAT), 32'd0);
         if (stall_prev) begin
            chk("stall_v", 32'(DAT_v), 32'd1);
            chk("stall_dat", 32'(DAT), 32'(stall_dat));
         end
         acc  = in_valid && in_ready;
         beat = DAT_v && DAT_r;
         if (beat) begin
            if (exp_words.size() == 0) begin
               chk("spurious_beat", 32'(DAT_v), 32'd0);
            end else begin
               w = exp_words[0];
               chk("beat_dat", 32'(DAT), (w >> (DW * idx)) & 32'hF);
               idx++;
               if (idx == BEATS) begin
                  void'(exp_words.pop_front());
                  idx = 0;
                  exp_ws = exp_ws + 16'd1;
               end
            end
         end
         stall_prev = DAT_v && !DAT_r;
         stall_dat  = DAT;
         if (acc) exp_words.push_back(in_dat);
      end
      @(posedge clock);
      if (!rn) begin
         exp_words.delete();
         idx        = 0;
         exp_ws     = 16'd0;
         model_on   = 1'b1;
         stall_prev = 1'b0;
      end
      @(negedge clock);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      DAT_r    = 1'b1;
      in_valid = 1'b0;
      while (exp_words.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(exp_words.size()), 32'd0);
   endtask

   initial begin
      int base;
      int k;
      logic [3:0] pat;

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_dat   = '0;
      DAT_r    = 1'b0;
      @(negedge clock);

      // Reset state, with the receiver ready and a word offered.
      in_valid = 1'b1;
      in_dat   = 32'h12345678;
      DAT_r    = 1'b1;
      tick();
      tick();
      chk("rst_dat_v", 32'(DAT_v), 32'd0);
      chk("rst_dat", 32'(DAT), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_words_sent", 32'(words_sent), 32'd0);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);

      // Single word, receiver always ready: beats 1..8 starting next cycle.
      in_valid = 1'b1;
      in_dat   = 32'h87654321;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         chk("single_v", 32'(DAT_v), 32'd1);
         chk("single_dat", 32'(DAT), 32'(i + 1));
         tick();
      end
      chk("single_end_v", 32'(DAT_v), 32'd0);
      chk("single_busy", 32'(busy), 32'd0);
      chk("single_words_sent", 32'(words_sent), 32'd1);

      // Three words back-to-back: 24 contiguous beats, FIFO full meanwhile.
      base     = int'(exp_ws);
      in_valid = 1'b1;
      in_dat   = 32'h11111111;
      tick();
      chk("b2b_v", 32'(DAT_v), 32'd1);
      in_dat = 32'h22222222;
      tick();
      chk("b2b_v", 32'(DAT_v), 32'd1);
      in_dat = 32'h33333333;
      tick();
      in_valid = 1'b0;
      chk("b2b_full", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3 * BEATS - 2; i++) begin
         chk("b2b_v", 32'(DAT_v), 32'd1);
         chk("b2b_ready", 32'(in_ready), 32'(int'(exp_ws) != base));
         tick();
      end
      chk("b2b_end_v", 32'(DAT_v), 32'd0);
      chk("b2b_words_sent", 32'(words_sent), 32'd4);

      // Receiver stalls with pattern 1,0,0,1 during 0xA5A5A5A5.
      base     = int'(exp_ws);
      pat      = 4'b1001;
      in_valid = 1'b1;
      in_dat   = 32'hA5A5A5A5;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (int'(exp_ws) == base && k < 64) begin
         DAT_r = pat[k % 4];
         tick();
         k++;
      end
      chk("stall_words_sent", 32'(words_sent), 32'(base + 1));

      // Push while the last beat completes with one word queued.
      DAT_r    = 1'b1;
      in_valid = 1'b1;
      in_dat   = 32'hCAFEF00D;
      tick();
      in_dat = 32'h0F1E2D3C;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (idx != BEATS - 1 && k < 20) begin
         tick();
         k++;
      end
      chk("push_last_pos", 32'(idx), 32'(BEATS - 1));
      in_valid = 1'b1;
      in_dat   = 32'h98BADCFE;
      tick();
      in_valid = 1'b0;
      chk("push_last_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 2 * BEATS; i++) begin
         chk("push_last_v", 32'(DAT_v), 32'd1);
         tick();
      end
      chk("push_last_end_v", 32'(DAT_v), 32'd0);

      // Reset mid-word with one word queued discards everything.
      in_valid = 1'b1;
      in_dat   = 32'hDEADBEEF;
      tick();
      in_dat = 32'h55AA55AA;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (idx != 4 && k < 20) begin
         tick();
         k++;
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("midrst_v", 32'(DAT_v), 32'd0);
      chk("midrst_words_sent", 32'(words_sent), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 20; i++) begin
         chk("midrst_quiet", 32'(DAT_v), 32'd0);
         tick();
      end

      // Randomized traffic and receiver back-pressure.
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_dat   = $urandom;
         DAT_r    = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain(200);

      // Counter wrap: preload near the top, then send two words.
      @(negedge clock);
      force dut.words_sent_q = 16'hFFFE;
      #1;
      release dut.words_sent_q;
      exp_ws = 16'hFFFE;
      @(negedge clock);
      in_valid = 1'b1;
      in_dat   = $urandom;
      tick();
      drain(20);
      chk("wrap_ffff", 32'(words_sent), 32'h0000FFFF);
      in_valid = 1'b1;
      in_dat   = $urandom;
      tick();
      drain(20);
      chk("wrap_zero", 32'(words_sent), 32'h00000000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
